// File: rtl/alu_bist_if.sv
// alu_bist_if: operand/opcode to result/zero link between the BIST controller and the ALU
interface alu_bist_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [3:0]            alu_op;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero;
    modport master (output alu_a, alu_b, alu_op, input alu_result, alu_zero);
    modport slave  (input alu_a, alu_b, alu_op, output alu_result, alu_zero);
endinterface

// File: rtl/alu_bist.sv
// alu_bist: drives LFSR operand vectors through AND/OR/ADD/SUB and folds results into a MISR
module alu_bist #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_VECTORS = 64,
    parameter logic [DATA_WIDTH-1:0] SEED_A      = 32'h1,
    parameter logic [DATA_WIDTH-1:0] SEED_B      = 32'hACE1,
    parameter logic [DATA_WIDTH-1:0] POLY        = 32'h04C11DB7,
    parameter logic [DATA_WIDTH-1:0] GOLDEN_SIG  = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    alu_bist_if.master            alu,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [DATA_WIDTH-1:0] signature
);
    localparam int IW = NUM_VECTORS > 1 ? $clog2(NUM_VECTORS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] lfsr_b;
    logic [IW-1:0]         idx;
    logic                  last_vec, last_op, launch;
    logic [3:0]            next_op;

    function automatic logic [DATA_WIDTH-1:0] step(input logic [DATA_WIDTH-1:0] x);
        return (x << 1) ^ (x[DATA_WIDTH-1] ? POLY : '0);
    endfunction

    assign last_vec = idx == IW'(NUM_VECTORS - 1);
    assign last_op  = alu.alu_op == 4'b0110;
    assign launch   = start && (state == IDLE || state == DONE);
    assign busy     = state == RUN || state == CHECK;
    assign next_op  = alu.alu_op == 4'b0000 ? 4'b0001 :
                      alu.alu_op == 4'b0001 ? 4'b0010 :
                      alu.alu_op == 4'b0010 ? 4'b0110 : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        state_nxt = launch         ? RUN   :
                    state == RUN   ? (last_vec && last_op ? CHECK : RUN) :
                    state == CHECK ? DONE  : state;
    end

    // alu_a doubles as the operand-A LFSR; alu_b mirrors A on index 0 so SUB sees a==b
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu.alu_a  <= '0;
            alu.alu_b  <= '0;
            alu.alu_op <= '0;
            lfsr_b     <= '0;
            idx        <= '0;
            signature  <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else if (launch) begin
            alu.alu_a  <= SEED_A;
            alu.alu_b  <= SEED_A;
            alu.alu_op <= 4'b0000;
            lfsr_b     <= SEED_B;
            idx        <= '0;
            signature  <= '1;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else if (state == RUN) begin
            signature <= step(signature) ^ alu.alu_result ^ {{(DATA_WIDTH-1){1'b0}}, alu.alu_zero};
            if (!last_vec) begin
                idx       <= idx + IW'(1);
                alu.alu_a <= step(alu.alu_a);
                alu.alu_b <= step(lfsr_b);
                lfsr_b    <= step(lfsr_b);
            end else begin
                idx        <= '0;
                alu.alu_a  <= SEED_A;
                alu.alu_b  <= SEED_A;
                lfsr_b     <= SEED_B;
                alu.alu_op <= next_op;
            end
        end else if (state == CHECK) begin
            pass <= signature == GOLDEN_SIG;
            done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: directed run sequence with random gaps/stray starts, checked against a vector-level model
module tb_alu_bist;
    localparam int          NV     = 4;
    localparam logic [31:0] SEED_A = 32'h1;
    localparam logic [31:0] SEED_B = 32'hACE1;
    localparam logic [31:0] POLY   = 32'h04C11DB7;

    // Signature after the first `upto` vectors have been absorbed, from the vector rules directly
    function automatic logic [31:0] model_sig(input int upto);
        logic [31:0] s, a, b, r, sa, sb;
        logic [3:0]  op;
        int          n;
        s = '1;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            op = k == 0 ? 4'h0 : k == 1 ? 4'h1 : k == 2 ? 4'h2 : 4'h6;
            sa = SEED_A;
            sb = SEED_B;
            for (int i = 0; i < NV; i++) begin
                a = sa;
                b = i == 0 ? sa : sb;
                r = op == 4'h0 ? a & b : op == 4'h1 ? a | b : op == 4'h2 ? a + b : a - b;
                if (n < upto) s = ((s << 1) ^ (s[31] ? POLY : 32'h0)) ^ r ^ {31'h0, r == 32'h0};
                n++;
                sa = (sa << 1) ^ (sa[31] ? POLY : 32'h0);
                sb = (sb << 1) ^ (sb[31] ? POLY : 32'h0);
            end
        end
        return s;
    endfunction

    localparam logic [31:0] GOLD = model_sig(4 * NV);

    function automatic logic [67:0] model_vec(input int j);
        logic [31:0] a, b;
        logic [3:0]  op;
        a  = SEED_A;
        b  = SEED_B;
        op = j / NV == 0 ? 4'h0 : j / NV == 1 ? 4'h1 : j / NV == 2 ? 4'h2 : 4'h6;
        for (int i = 0; i < j % NV; i++) begin
            a = (a << 1) ^ (a[31] ? POLY : 32'h0);
            b = (b << 1) ^ (b[31] ? POLY : 32'h0);
        end
        return {op, a, (j % NV == 0) ? a : b};
    endfunction

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b1;
    logic        fault = 1'b0;
    logic        busy, done, pass;
    logic [31:0] signature, res;
    int          total = 0;
    int          passed = 0;

    alu_bist_if #(.DATA_WIDTH(32)) alu ();

    alu_bist #(
        .DATA_WIDTH(32), .NUM_VECTORS(NV), .SEED_A(SEED_A), .SEED_B(SEED_B),
        .POLY(POLY), .GOLDEN_SIG(GOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu(alu),
        .busy(busy), .done(done), .pass(pass), .signature(signature)
    );

    always #5 clk = ~clk;

    // Behavioural ALU with an optional stuck-at-0 on result bit 0
    always_comb begin
        res = alu.alu_op == 4'h0 ? alu.alu_a & alu.alu_b :
              alu.alu_op == 4'h1 ? alu.alu_a | alu.alu_b :
              alu.alu_op == 4'h2 ? alu.alu_a + alu.alu_b :
              alu.alu_op == 4'h6 ? alu.alu_a - alu.alu_b : 32'h0;
        alu.alu_result = fault ? {res[31:1], 1'b0} : res;
        alu.alu_zero   = res == 32'h0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_a"}, alu.alu_a, 0);
        chk({tag, "_b"}, alu.alu_b, 0);
        chk({tag, "_op"}, {28'h0, alu.alu_op}, 0);
        chk({tag, "_busy"}, {31'h0, busy}, 0);
        chk({tag, "_done"}, {31'h0, done}, 0);
        chk({tag, "_pass"}, {31'h0, pass}, 0);
        chk({tag, "_sig"}, signature, 0);
    endtask

    // Called at #1 after an edge; start is sampled at the next edge (edge 0 of the run)
    task automatic run_test(input bit stray, input bit faulty);
        int rnd = $urandom_range(2, 15);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_drop", {31'h0, done}, 0);
        for (int c = 1; c <= 4 * NV; c++) begin
            logic [67:0] v;
            v = model_vec(c - 1);
            chk("busy", {31'h0, busy}, 1);
            chk("op", {28'h0, alu.alu_op}, {28'h0, v[67:64]});
            chk("a", alu.alu_a, v[63:32]);
            chk("b", alu.alu_b, v[31:0]);
            if (!faulty) chk("sig_step", signature, model_sig(c - 1));
            if (c == 3 * NV + 1) chk("sub_zero", {31'h0, alu.alu_zero}, 1);
            start = stray && (c == 3 || c == 16 || c == rnd);
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("check_busy", {31'h0, busy}, 1);
        chk("check_done", {31'h0, done}, 0);
        @(posedge clk); #1;
        chk("done", {31'h0, done}, 1);
        chk("end_busy", {31'h0, busy}, 0);
        chk("pass", {31'h0, pass}, {31'h0, !faulty});
        if (faulty) begin
            total++;
            assert (signature !== GOLD) passed++;
            else $error("FAIL fault_sig: observed %h expected anything but %h", signature, GOLD);
        end else chk("final_sig", signature, GOLD);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_idle_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_zero("idle");
        run_test(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("hold_done", {31'h0, done}, 1);
        chk("hold_pass", {31'h0, pass}, 1);
        chk("hold_sig", signature, GOLD);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        run_test(1'b1, 1'b0);
        fault = 1'b1;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        run_test(1'b0, 1'b1);
        fault = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_busy", {31'h0, busy}, 1);
        rst_n = 1'b0;
        #1;
        chk_idle_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_test(1'b0, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_bist.md
# alu_bist

Built-in self-test controller for the execute-stage ALU. On a start pulse it drives the ALU operand and opcode inputs with pseudo-random vectors for every supported operation (AND, OR, ADD, SUB). It compresses each returned result and zero flag into a MISR signature, then compares the signature against a golden value. It sits beside the ALU behind the datapath operand muxes and is the initiator side of the ALU's a/b/ALUOp → result/zero interface.

## Interface
- DATA_WIDTH, `DATA_WIDTH (32): operand/result width.
- NUM_VECTORS, 64: vectors applied per opcode; ≥1.
- SEED_A, 32'h1: operand-A LFSR seed; nonzero.
- SEED_B, 32'hACE1: operand-B LFSR seed; nonzero.
- POLY, 32'h04C11DB7: feedback polynomial for both LFSRs and the MISR.
- GOLDEN_SIG, 32'h0: expected final signature.
- clk  in  1: clock, rising edge.
- rst_n  in  1: asynchronous active-low reset.
- start  in  1: single-cycle request to run the test.
- alu_result  in  DATA_WIDTH: ALU result, combinational from alu_a/alu_b/alu_op.
- alu_zero  in  1: ALU zero flag.
- alu_a  out  DATA_WIDTH: operand A, registered.
- alu_b  out  DATA_WIDTH: operand B, registered.
- alu_op  out  4: ALUOp, registered.
- busy  out  1: test in progress.
- done  out  1: test finished; pass valid.
- pass  out  1: signature matched GOLDEN_SIG.
- signature  out  DATA_WIDTH: current MISR value.

## Operation
- States: IDLE, RUN, CHECK, DONE.
- Opcode order: 4'b0000 AND, 4'b0001 OR, 4'b0010 ADD, 4'b0110 SUB.
- IDLE/DONE + start:
  - go to RUN
  - lfsr_a←SEED_A, lfsr_b←SEED_B
  - alu_op←0000, vector index←0
  - signature←all ones
  - done←0, pass←0
- Operand rule:
  - alu_a = lfsr_a.
  - alu_b = lfsr_a on vector index 0 of each opcode, so a==b (SUB yields zero=1). Otherwise alu_b = lfsr_b.
- LFSR step (Galois): x ← (x<<1) ^ (x[W-1] ? POLY : 0).
- RUN, every edge:
  - Absorb the current vector: sig ← (sig<<1) ^ (sig[W-1] ? POLY : 0) ^ alu_result ^ {{W-1{0}}, alu_zero}.
  - If index < NUM_VECTORS-1: increment the index and step both LFSRs.
  - Otherwise: clear the index, reload both seeds, and advance alu_op to the next opcode.
  - After the SUB last vector: go to CHECK, with alu_op returning to 0000.
- CHECK: one cycle. pass←(signature==GOLDEN_SIG), done←1, go to DONE.
- DONE: hold done, pass, and signature until the next start.
- start is ignored in RUN and CHECK.
- All arithmetic is modulo 2^DATA_WIDTH. No carry or overflow is observed.

## Timing
- Reset value of every output is 0: alu_a, alu_b, alu_op, busy, done, pass, signature. FSM resets to IDLE.
- start sampled at edge k:
  - busy=1 from after edge k.
  - Vector i (0-based, across all ops) is driven during the cycle after edge k+i and absorbed at edge k+i+1.
- Last vector absorbed at edge k+4·NUM_VECTORS. CHECK runs during the following cycle.
- Edge k+4·NUM_VECTORS+1: done=1, pass valid, busy=0.
- Total latency from start to done is 4·NUM_VECTORS+1 cycles.
- Restart from DONE takes effect at the same edge start is sampled: done drops after that edge.
- rst_n low mid-run: immediate asynchronous return to reset values. A partial signature is discarded.

## Test plan
- Reset: hold rst_n=0 with start=1 → all outputs 0, no run starts. Release → still IDLE until a start pulse.
- Sequencing, NUM_VECTORS=4, start at edge 0:
  - alu_op = 0000 for cycles 1–4, 0001 for 5–8, 0010 for 9–12, 0110 for 13–16.
  - Cycle 1: alu_a=alu_b=SEED_A.
  - Cycle 13 (SUB index 0): alu_zero=1 from a correct ALU.
  - done=1 after edge 17.
- Pass path: correct ALU, GOLDEN_SIG set to the bench model's signature → pass=1, and signature equals the model value at every absorb edge.
- Fault detection: force alu_result[0] stuck-at-0 → done=1 at the same cycle, pass=0, signature ≠ GOLDEN_SIG.
- start pulses at cycles 3 and 16 (busy) → ignored, done still at edge 17. start again in DONE → new run, identical signature.
- Reset mid-run: rst_n=0 at cycle 6 → outputs 0 immediately. New start → full run, pass=1.
